mips_fetch_decode: RTL and testbench
====================================

Name: mips_fetch_decode

Overview:
- Instruction fetch + decode stage directly upstream of the I-type register-read/ALU stage.
- Holds the PC and a loadable word-addressed instruction memory.
- Registers the fetched word in an IF/ID pipeline register and splits it into OpCode/rs/rt/rd/imm/funct fields plus class flags.
- Supports stall, redirect (branch/jump) with flush, and a HALT state.

Parameters:
ADDR_W, 6, instruction memory index width; depth = 2**ADDR_W words
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
stall  input  1  hold PC and IF/ID contents this cycle
redirect  input  1  load redirect_pc into PC and flush IF/ID
redirect_pc  input  32  branch/jump target (byte address)
load_en  input  1  write instruction memory
load_addr  input  ADDR_W  word index to write
load_data  input  32  instruction word to write
pc_out  output  32  PC of the instruction held in IF/ID
OpCode  output  6  instr[31:26]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
imm  output  16  instr[15:0]
imm_sext  output  32  imm sign-extended to 32 bits
funct  output  6  instr[5:0]
is_r  output  1  OpCode == 6'b000000
is_j  output  1  OpCode == 6'b000010 or 6'b000011
is_i  output  1  valid, not R, not J, not HALT opcode
valid  output  1  IF/ID holds a real instruction
halted  output  1  FSM in HALT

Behaviour:
- Reset (rst_n low at posedge) forces:
  - PC = RESET_PC; valid = 0; halted = 0; FSM = RUN.
  - Instruction register = 0, so all field outputs and flags read 0.
  - Memory contents are not cleared.
- Memory:
  - Read index = PC[ADDR_W+1:2], combinational read.
  - Write is synchronous on load_en, permitted in any state.
  - Write and fetch to the same index in the same cycle: the fetch captures the old word.
- Decoded outputs are pure functions of the IF/ID instruction register.
- Latency: a word at PC appears on the outputs one cycle after that PC is presented; pc_out travels with it.
- FSM RUN, priority order:
  - redirect=1: PC <- {redirect_pc[31:2],2'b00}; IF/ID instr <- 0, valid <- 0 (bubble). Redirect overrides stall.
  - else stall=1: PC, IF/ID, and valid all hold.
  - else: IF/ID <- mem[index], pc_out <- PC, valid <- 1, PC <- PC + 4.
  - PC is 32-bit, wrapping modulo 2^32. The memory index wraps modulo depth, so fetch after the last word returns word 0.
- HALT:
  - Entered when RUN captures a word with opcode 6'b111111 into IF/ID, with no stall and no redirect.
  - The HALT word is presented for one cycle with valid=1, is_i=0, is_r=0, is_j=0.
  - On the next edge: halted=1, valid=0, PC frozen at the HALT address + 4.
  - HALT ignores stall and redirect. Only reset leaves HALT.
- Reset asserted mid-stall or mid-HALT: same result as reset from idle.
- redirect_pc[1:0] is ignored (forced word alignment).

Test Plan:
- Load mem[0]=32'h2067_0064 (ADDI R7,R3,100) and mem[1]=32'h2086_00C8 (ADDI R6,R4,200); release reset.
  - Cycle 1: OpCode=6'h08, rs=3, rt=7, imm=100, imm_sext=100, is_i=1, pc_out=0, valid=1.
  - Cycle 2: rs=4, rt=6, imm=200, pc_out=4.
- Load mem[2]=32'hFFFF_FF00 with opcode 6'b111111.
  - Third fetch shows valid=1 with is_i=is_r=is_j=0.
  - Next cycle: halted=1, valid=0, PC=12.
  - Asserting redirect while halted causes no change.
- Stall for 3 cycles after the first fetch: outputs, pc_out=0 and valid=1 stay frozen. On release, the next word comes from PC=4.
- Assert redirect with redirect_pc=32'h0000_0013 together with stall:
  - Next cycle: valid=0 and all fields 0.
  - Following cycle: fetches index 4, pc_out=16.
- Sign extension: mem[0]=32'h2067_FF9C gives imm=16'hFF9C, imm_sext=32'hFFFF_FF9C. mem[1]=32'h0000_0020 gives is_r=1, funct=6'h20.
- Index wrap: with ADDR_W=2, fetch with no stall, no redirect and no HALT word in memory. After pc_out=12, the next fetch has pc_out=16 and returns mem[0].
- Reset mid-run: pull rst_n low for one edge while valid=1. Required response: valid=0, outputs 0, next fetch from RESET_PC. Memory contents are preserved.

Source files
------------

// File: rtl/mips_fetch_decode.sv
// MIPS instruction fetch + decode: PC, loadable word-addressed instruction memory,
// IF/ID register with field split and class flags, stall/redirect/HALT control.
module mips_fetch_decode #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       pc_out,
  output logic [5:0]        OpCode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic [31:0]       imm_sext,
  output logic [5:0]        funct,
  output logic              is_r,
  output logic              is_j,
  output logic              is_i,
  output logic              valid,
  output logic              halted
);

  localparam int         DEPTH   = 2 ** ADDR_W;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // DRAIN is the single cycle in which the HALT word is presented downstream.
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t              state;
  logic [31:0]         mem [DEPTH];
  logic [31:0]         pc;
  logic [31:0]         instr_p0;
  logic [ADDR_W-1:0]   fetch_idx;
  logic [31:0]         fetch_word;
  logic signed [15:0]  imm_s;

  // Fetch stage: combinational read, so a same-cycle write is seen only next time
  assign fetch_idx  = pc[ADDR_W+1:2];
  assign fetch_word = mem[fetch_idx];

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      instr_p0 <= '0;
      pc_out   <= '0;
      valid    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (redirect) begin
            pc       <= redirect_pc & ~32'h3;
            instr_p0 <= '0;
            valid    <= 1'b0;
          end else if (!stall) begin
            instr_p0 <= fetch_word;
            pc_out   <= pc;
            valid    <= 1'b1;
            pc       <= pc + 32'd4;
            if (fetch_word[31:26] == OP_HALT) state <= DRAIN;
          end
        end
        DRAIN: begin
          state  <= HALT;
          halted <= 1'b1;
          valid  <= 1'b0;
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

  // Decode stage: pure functions of the IF/ID register
  assign imm_s    = instr_p0[15:0];
  assign OpCode   = instr_p0[31:26];
  assign rs       = instr_p0[25:21];
  assign rt       = instr_p0[20:16];
  assign rd       = instr_p0[15:11];
  assign imm      = instr_p0[15:0];
  assign imm_sext = {{16{imm_s[15]}}, imm_s};
  assign funct    = instr_p0[5:0];

  assign is_r = valid && (OpCode == 6'b000000);
  assign is_j = valid && ((OpCode == 6'b000010) || (OpCode == 6'b000011));
  assign is_i = valid && !is_r && !is_j && (OpCode != OP_HALT);

endmodule

// File: tb/tb_mips_fetch_decode.sv
// Randomized + directed bench for mips_fetch_decode against a behavioural model.
module tb_mips_fetch_decode;

  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n, stall, redirect, load_en;
  logic [31:0]   redirect_pc, load_data;
  logic [AW-1:0] load_addr;
  logic [31:0]   pc_out, imm_sext;
  logic [5:0]    OpCode, funct;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic          is_r, is_j, is_i, valid, halted;

  mips_fetch_decode #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .pc_out(pc_out), .OpCode(OpCode), .rs(rs), .rt(rt),
    .rd(rd), .imm(imm), .imm_sext(imm_sext), .funct(funct), .is_r(is_r),
    .is_j(is_j), .is_i(is_i), .valid(valid), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_instr, m_pcout;
  logic        m_valid, m_halted, m_pending;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the architectural rules
  task automatic model_step();
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = '0; m_pcout = '0;
      m_valid = 1'b0; m_halted = 1'b0; m_pending = 1'b0;
    end else if (m_halted) begin
    end else if (m_pending) begin
      m_halted = 1'b1; m_valid = 1'b0; m_pending = 1'b0;
    end else if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00}; m_instr = '0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = m_mem[(m_pc / 4) % DEPTH];
      m_pcout = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
      if (m_instr[31:26] == 6'h3F) m_pending = 1'b1;
    end
    if (load_en) m_mem[load_addr] = load_data;
  endtask

  task automatic compare_all();
    logic [5:0] op;
    logic       e_r, e_j, e_i;
    op  = m_instr[31:26];
    e_r = m_valid && (op == 6'd0);
    e_j = m_valid && (op == 6'd2 || op == 6'd3);
    e_i = m_valid && !e_r && !e_j && (op != 6'h3F);
    check_val("valid",    32'(valid),    32'(m_valid));
    check_val("halted",   32'(halted),   32'(m_halted));
    check_val("pc_out",   pc_out,        m_pcout);
    check_val("OpCode",   32'(OpCode),   32'(op));
    check_val("rs",       32'(rs),       32'(m_instr[25:21]));
    check_val("rt",       32'(rt),       32'(m_instr[20:16]));
    check_val("rd",       32'(rd),       32'(m_instr[15:11]));
    check_val("imm",      32'(imm),      32'(m_instr[15:0]));
    check_val("imm_sext", imm_sext,      32'(signed'(m_instr[15:0])));
    check_val("funct",    32'(funct),    32'(m_instr[5:0]));
    check_val("is_r",     32'(is_r),     32'(e_r));
    check_val("is_j",     32'(is_j),     32'(e_j));
    check_val("is_i",     32'(is_i),     32'(e_i));
  endtask

  task automatic tick(input logic s, input logic r, input logic [31:0] rp);
    stall = s; redirect = r; redirect_pc = rp;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ld(input int a, input logic [31:0] d);
    load_en = 1'b1; load_addr = AW'(a); load_data = d;
    tick(1'b1, 1'b0, 32'h0);
    load_en = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    m_pc = '0; m_instr = '0; m_pcout = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_pending = 1'b0;

    // Fill memory with ADDI words while held in reset
    for (int i = 0; i < DEPTH; i++) ld(i, 32'h2000_0000 | 32'(i));
    ld(0, 32'h2067_0064);
    ld(1, 32'h2086_00C8);
    ld(2, 32'hFFFF_FF00);
    check_val("rst_valid", 32'(valid), 32'd0);
    check_val("rst_op",    32'(OpCode), 32'd0);

    // Two ADDIs then HALT
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    check_val("f1_op",   32'(OpCode), 32'h08);
    check_val("f1_rs",   32'(rs),     32'd3);
    check_val("f1_rt",   32'(rt),     32'd7);
    check_val("f1_imm",  32'(imm),    32'd100);
    check_val("f1_sext", imm_sext,    32'd100);
    check_val("f1_isi",  32'(is_i),   32'd1);
    check_val("f1_pc",   pc_out,      32'd0);
    tick(1'b0, 1'b0, 32'h0);
    check_val("f2_rs",   32'(rs),     32'd4);
    check_val("f2_rt",   32'(rt),     32'd6);
    check_val("f2_imm",  32'(imm),    32'd200);
    check_val("f2_pc",   pc_out,      32'd4);
    tick(1'b0, 1'b0, 32'h0);
    check_val("h_valid", 32'(valid),  32'd1);
    check_val("h_flags", 32'({is_i, is_r, is_j}), 32'd0);
    tick(1'b0, 1'b0, 32'h0);
    check_val("h_halted", 32'(halted), 32'd1);
    check_val("h_vld0",   32'(valid),  32'd0);
    tick(1'b0, 1'b1, 32'h40);
    tick(1'b0, 1'b0, 32'h0);
    check_val("h_stay",   32'(halted), 32'd1);
    check_val("h_vld1",   32'(valid),  32'd0);

    // Stall after first fetch
    rst_n = 1'b0;
    ld(2, 32'h2000_0002);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);
    check_val("st_pc",  pc_out,      32'd0);
    check_val("st_vld", 32'(valid),  32'd1);
    check_val("st_rs",  32'(rs),     32'd3);
    tick(1'b0, 1'b0, 32'h0);
    check_val("st_next", pc_out, 32'd4);

    // Redirect overrides stall, low bits dropped
    tick(1'b1, 1'b1, 32'h0000_0013);
    check_val("rd_vld", 32'(valid),  32'd0);
    check_val("rd_op",  32'(OpCode), 32'd0);
    check_val("rd_imm", 32'(imm),    32'd0);
    tick(1'b0, 1'b0, 32'h0);
    check_val("rd_pc",  pc_out,      32'd16);
    check_val("rd_imm4", 32'(imm),   32'd4);

    // Sign extension and R-type
    rst_n = 1'b0;
    ld(0, 32'h2067_FF9C);
    ld(1, 32'h0000_0020);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    check_val("sx_imm",  32'(imm), 32'h0000_FF9C);
    check_val("sx_sext", imm_sext, 32'hFFFF_FF9C);
    tick(1'b0, 1'b0, 32'h0);
    check_val("r_isr",   32'(is_r),  32'd1);
    check_val("r_funct", 32'(funct), 32'h20);

    // Index wrap: run through all words
    for (int i = 2; i < DEPTH; i++) tick(1'b0, 1'b0, 32'h0);
    check_val("wr_last", pc_out, 32'(4 * (DEPTH - 1)));
    tick(1'b0, 1'b0, 32'h0);
    check_val("wr_pc",  pc_out,    32'(4 * DEPTH));
    check_val("wr_imm", 32'(imm),  32'h0000_FF9C);

    // Reset mid-run, memory preserved
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    check_val("mr_vld", 32'(valid),  32'd0);
    check_val("mr_op",  32'(OpCode), 32'd0);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    check_val("mr_pc",  pc_out,   32'd0);
    check_val("mr_imm", 32'(imm), 32'h0000_FF9C);

    // Write and fetch same index: fetch sees old word
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    load_en = 1'b1; load_addr = '0; load_data = 32'h2000_1234;
    tick(1'b0, 1'b0, 32'h0);
    load_en = 1'b0;
    check_val("wf_old", 32'(imm), 32'h0000_FF9C);
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    check_val("wf_new", 32'(imm), 32'h0000_1234);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst_n   = ($urandom_range(0, 39) != 0);
      load_en = ($urandom_range(0, 4) == 0);
      load_addr = AW'($urandom_range(0, DEPTH - 1));
      w = $urandom;
      if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31:26] = 6'h08;
      load_data = w;
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           32'($urandom_range(0, 511)));
    end
    load_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
